// File: rtl/modport_alu.sv
// Registered single-cycle ALU: ADD/SUB with signed overflow, bitwise logic,
// range-checked shifts and signed compare. Result and error appear one edge after the operands.
`timescale 1ns/1ps
module modport_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       opcode,
  output logic [WIDTH-1:0] result,
  output logic             error
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRA = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic [WIDTH-1:0] result_q, result_d;
  logic             error_q, error_d;
  logic [WIDTH-1:0] sum, diff;
  logic [SW-1:0]    shamt;
  logic             shamt_oor;
  logic             lt;

  assign sum   = A + B;
  assign diff  = A - B;
  assign shamt = B[SW-1:0];
  // Any bit above the shift-index field set means the amount is >= WIDTH.
  assign shamt_oor = |B[WIDTH-1:SW];
  assign lt = $signed(A) < $signed(B);

  always_comb begin
    result_d = '0;
    error_d  = 1'b0;
    case (opcode)
      OP_ADD: begin
        result_d = sum;
        error_d  = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        result_d = diff;
        error_d  = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND: result_d = A & B;
      OP_OR:  result_d = A | B;
      OP_XOR: result_d = A ^ B;
      OP_SLL: begin
        if (shamt_oor) begin
          result_d = '0;
          error_d  = 1'b1;
        end else begin
          result_d = A << shamt;
        end
      end
      OP_SRA: begin
        if (shamt_oor) begin
          result_d = {WIDTH{A[WIDTH-1]}};
          error_d  = 1'b1;
        end else begin
          result_d = $signed(A) >>> shamt;
        end
      end
      OP_SLT: result_d = {{(WIDTH-1){1'b0}}, lt};
      default: begin
        result_d = '0;
        error_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      error_q  <= error_d;
    end
  end

  assign result = result_q;
  assign error  = error_q;

endmodule

// File: tb/tb_modport_alu.sv
// Scoreboard bench for modport_alu: driver pushes model expectations at each
// capturing edge, an independent monitor pops and compares after the edge.
`timescale 1ns/1ps
module tb_modport_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic [2:0]  op;
  logic [31:0] result;
  logic        error;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] res;
    logic        err;
    string       name;
  } exp_t;

  exp_t sb[$];

  localparam longint MAXP = 64'sd2147483647;
  localparam longint MINN = -64'sd2147483648;

  modport_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .A(a), .B(b), .opcode(op),
    .result(result), .error(error)
  );

  always #5 clk = ~clk;

  // Reference model: plain wide-integer arithmetic on the operation rules.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic [2:0] o);
    exp_t e;
    longint sx, sy, r, d, q;
    longint unsigned ux;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.res = '0;
    e.err = 1'b0;
    e.name = "";
    case (o)
      3'd0: begin r = sx + sy; e.err = (r > MAXP) || (r < MINN); e.res = r[31:0]; end
      3'd1: begin r = sx - sy; e.err = (r > MAXP) || (r < MINN); e.res = r[31:0]; end
      3'd2: e.res = x & y;
      3'd3: e.res = x | y;
      3'd4: e.res = x ^ y;
      3'd5: begin
        if (y >= 32) begin e.res = 32'd0; e.err = 1'b1; end
        else begin ux = longint'(x) * (64'd1 << y); e.res = ux[31:0]; end
      end
      3'd6: begin
        if (y >= 32) begin e.res = (sx < 0) ? 32'hFFFF_FFFF : 32'd0; e.err = 1'b1; end
        else begin
          d = longint'(64'd1 << y);
          q = sx / d;
          if ((sx % d != 0) && (sx < 0)) q = q - 1;
          e.res = q[31:0];
        end
      end
      default: e.res = (sx < sy) ? 32'd1 : 32'd0;
    endcase
    return e;
  endfunction

  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [2:0] o, input string nm);
    exp_t e;
    @(negedge clk);
    a = x; b = y; op = o;
    @(posedge clk);
    if (rst) begin
      e = model(x, y, o);
      e.name = nm;
      sb.push_back(e);
    end
  endtask

  task automatic chk_zero(input string nm);
    checks++;
    if (result !== 32'd0 || error !== 1'b0) begin
      failures++;
      $display("FAIL %s: result=%h error=%b expected result=00000000 error=0", nm, result, error);
    end
  endtask

  // Monitor: every edge's outcome is visible 1ns later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (result !== e.res || error !== e.err) begin
          failures++;
          $display("FAIL %s: result=%h error=%b expected result=%h error=%b",
                   e.name, result, error, e.res, e.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] x, y;
    logic [2:0]  o;
    rst = 1'b0; a = '0; b = '0; op = '0;
    #1;
    chk_zero("reset_state");
    repeat (2) @(negedge clk);
    a = 32'h1234_5678; b = 32'h1; op = 3'd0;
    @(posedge clk); #1;
    chk_zero("reset_hold_inputs");
    @(negedge clk);
    rst = 1'b1;

    issue(32'h7FFF_FFFF, 32'd1,          3'd0, "add_ovf");
    issue(32'd5,         32'hFFFF_FFFD,  3'd0, "add_5_m3");
    issue(32'h8000_0000, 32'd1,          3'd1, "sub_ovf");
    issue(32'd10,        32'd3,          3'd1, "sub_10_3");
    issue(32'hF0F0_F0F0, 32'hFF00_FF00,  3'd2, "and");
    issue(32'hF0F0_F0F0, 32'hFF00_FF00,  3'd3, "or");
    issue(32'hF0F0_F0F0, 32'hFF00_FF00,  3'd4, "xor");
    issue(32'd1,         32'd31,         3'd5, "sll_31");
    issue(32'h8000_0000, 32'd4,          3'd6, "sra_4");
    issue(32'd1,         32'd32,         3'd5, "sll_32");
    issue(32'h8000_0000, 32'd32,         3'd6, "sra_32_neg");
    issue(32'h7000_0000, 32'hFFFF_FFFF,  3'd6, "sra_big_pos");
    issue(32'hFFFF_FFFF, 32'd1,          3'd7, "slt_m1_1");
    issue(32'd1,         32'hFFFF_FFFF,  3'd7, "slt_1_m1");
    issue(32'h8000_0000, 32'h8000_0000,  3'd0, "add_neg_ovf");
    issue(32'd3,         32'd4,          3'd0, "add_no_err_after_ovf");

    // Async reset after an overflow, between edges.
    issue(32'h7FFF_FFFF, 32'd1, 3'd0, "add_ovf_pre_reset");
    #3;
    rst = 1'b0;
    #1;
    chk_zero("async_reset_clear");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
      chk_zero("reset_hold_random");
    end
    @(negedge clk);
    rst = 1'b1;
    issue(32'd10, 32'd3, 3'd1, "first_edge_after_reset");

    // In-flight operands discarded by a reset that lands before their edge.
    @(negedge clk);
    a = 32'h7FFF_FFFF; b = 32'd1; op = 3'd0;
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    chk_zero("inflight_discard");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 300; i++) begin
      x = $urandom;
      o = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: y = $urandom;
        1: y = 32'($urandom_range(0, 40));
        2: y = x;
        default: y = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) x = {1'b0, {31{1'b1}}};
      issue(x, y, o, "random");
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: pending=%0d expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/modport_alu.md
MODPORT_ALU -- requirements
Module: modport_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand and result width; all requirements below assume WIDTH=32.
REQ-002 SHALL have one clock and an asynchronous, active-low reset; reset polarity and synchronicity are fixed.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous active-low reset; 0 = in reset.
REQ-005 A  input  32  operand 1, signed two's complement.
REQ-006 B  input  32  operand 2; two's complement for ADD/SUB/SLT, unsigned shift amount for shifts.
REQ-007 opcode  input  3  operation select.
REQ-008 result  output  32  registered operation result.
REQ-009 error  output  1  registered error flag.

Function
REQ-010 Inputs SHALL be stable before each rising clk edge, since the environment changes them on the falling edge.
REQ-011 On each rising edge with rst=1, result and error SHALL register the outcome of the A, B and opcode values present at that edge (latency 1 cycle, no handshake).
REQ-012 opcode 000 ADD: result SHALL equal A+B mod 2^32; error=1 iff signed overflow (operands same sign, sum sign differs).
REQ-013 opcode 001 SUB: result SHALL equal A-B mod 2^32; error=1 iff signed overflow (operands differ in sign, difference sign differs from A).
REQ-014 opcode 010 AND: result SHALL equal A & B; error=0.
REQ-015 opcode 011 OR: result SHALL equal A | B; error=0.
REQ-016 opcode 100 XOR: result SHALL equal A ^ B; error=0.
REQ-017 opcode 101 SLL: if B<32, result SHALL equal A<<B[4:0] with error=0; if B>=32, result SHALL be 0 and error=1.
REQ-018 opcode 110 SRA: if B<32, result SHALL equal A arithmetically shifted right by B[4:0] (sign fill) with error=0; if B>=32, result SHALL be all copies of A[31] and error=1.
REQ-019 opcode 111 SLT: result SHALL be 32'd1 if signed A < signed B, else 0; error=0.
REQ-020 On ADD/SUB overflow, result SHALL still hold the wrapped value.
REQ-021 error SHALL reflect only the current registered operation and is not sticky.
REQ-022 X/Z on opcode is outside the contract; the design SHALL NOT be required to handle it.

Reset
REQ-023 When rst=0, result SHALL go to 32'h0 and error to 0 immediately, without waiting for clk.
REQ-024 While rst=0, outputs SHALL hold 0 regardless of inputs.
REQ-025 After rst rises, the first rising edge SHALL register a valid operation.
REQ-026 Reset asserted mid-stream SHALL discard any in-flight result.

Verification
REQ-027 ADD A=32'h7FFFFFFF, B=1 -> next edge result=32'h80000000, error=1; A=5, B=-3 -> result=2, error=0.
REQ-028 SUB A=32'h80000000, B=1 -> result=32'h7FFFFFFF, error=1; A=10, B=3 -> result=7, error=0.
REQ-029 AND/OR/XOR A=32'hF0F0F0F0, B=32'hFF00FF00 -> F000F000 / FFF0FFF0 / 0FF00FF0, error=0.
REQ-030 Shifts: SLL A=1, B=31 -> 32'h80000000; SRA A=32'h80000000, B=4 -> 32'hF8000000; SLL B=32 -> result=0, error=1.
REQ-031 SLT A=-1, B=1 -> result=1; A=1, B=-1 -> result=0.
REQ-032 Drive rst=0 between edges after an overflow -> result=0 and error=0 before the next clk edge; outputs stay 0 until rst=1 plus one edge.
